// File: rtl/dm_cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : dm_cache_controller
// Purpose  : Direct-mapped, write-back, write-allocate cache controller with
//            one 32-bit word per line. Tag, data, valid and dirty state are
//            held in flops. A single outstanding CPU request is serviced at
//            a time; misses go to a RAM controller through a request/response
//            pair of single-cycle strobes.
// Ports    : clk                 rising-edge clock
//            rst                 synchronous reset, active low
//            cpu_valid/rw/addr/wdata   CPU request (sampled only in IDLE)
//            cpu_rdata/cpu_ready       CPU completion (one-cycle pulse)
//            cache_to_mem_*      request to RAM controller (addr/data/rw/valid)
//            mem_to_cache_*      response from RAM controller (data/ready)
// Revision : 1.0  initial release
// ============================================================================
module dm_cache_controller #(
    parameter int LINES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_valid,
    input  logic        cpu_rw,
    input  logic [19:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic [19:0] cache_to_mem_addr,
    output logic [31:0] cache_to_mem_data,
    output logic        cache_to_mem_rw,
    output logic        cache_to_mem_valid,
    input  logic [31:0] mem_to_cache_data,
    input  logic        mem_to_cache_ready
);

    localparam int INDEX_W = $clog2(LINES);
    localparam int TAG_W   = 20 - INDEX_W;

    localparam logic [2:0] C_IDLE    = 3'd0;
    localparam logic [2:0] C_COMPARE = 3'd1;
    localparam logic [2:0] C_WB_REQ  = 3'd2;
    localparam logic [2:0] C_WB_WAIT = 3'd3;
    localparam logic [2:0] C_AL_REQ  = 3'd4;
    localparam logic [2:0] C_AL_WAIT = 3'd5;

    logic [2:0]         state_q, state_d;
    logic               req_rw_q, req_rw_d;
    logic [19:0]        req_addr_q, req_addr_d;
    logic [31:0]        req_wdata_q, req_wdata_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [LINES-1:0]   dirty_q, dirty_d;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [TAG_W-1:0]   tag_d  [LINES];
    logic [31:0]        data_q [LINES];
    logic [31:0]        data_d [LINES];

    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit;

    assign w_index = req_addr_q[INDEX_W-1:0];
    assign w_tag   = req_addr_q[19:INDEX_W];
    assign w_hit   = valid_q[w_index] && (tag_q[w_index] == w_tag);

    always_comb begin
        state_d     = state_q;
        req_rw_d    = req_rw_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        tag_d       = tag_q;
        data_d      = data_q;

        cpu_rdata          = 32'd0;
        cpu_ready          = 1'b0;
        cache_to_mem_addr  = 20'd0;
        cache_to_mem_data  = 32'd0;
        cache_to_mem_rw    = 1'b0;
        cache_to_mem_valid = 1'b0;

        case (state_q)
            C_IDLE: begin
                if (cpu_valid) begin
                    req_rw_d    = cpu_rw;
                    req_addr_d  = cpu_addr;
                    req_wdata_d = cpu_wdata;
                    state_d     = C_COMPARE;
                end
            end

            C_COMPARE: begin
                if (w_hit) begin
                    cpu_ready = 1'b1;
                    if (req_rw_q) begin
                        data_d[w_index]  = req_wdata_q;
                        dirty_d[w_index] = 1'b1;
                    end else begin
                        cpu_rdata = data_q[w_index];
                    end
                    state_d = C_IDLE;
                end else if (valid_q[w_index] && dirty_q[w_index]) begin
                    state_d = C_WB_REQ;
                end else begin
                    state_d = C_AL_REQ;
                end
            end

            // The victim line is untouched until WB_WAIT completes, so the
            // write-back fields are simply re-derived from it in both states.
            C_WB_REQ, C_WB_WAIT: begin
                cache_to_mem_addr  = {tag_q[w_index], w_index};
                cache_to_mem_data  = data_q[w_index];
                cache_to_mem_rw    = 1'b1;
                cache_to_mem_valid = (state_q == C_WB_REQ);
                if (state_q == C_WB_REQ) begin
                    state_d = C_WB_WAIT;
                end else if (mem_to_cache_ready) begin
                    dirty_d[w_index] = 1'b0;
                    state_d          = C_AL_REQ;
                end
            end

            C_AL_REQ, C_AL_WAIT: begin
                cache_to_mem_addr  = req_addr_q;
                cache_to_mem_valid = (state_q == C_AL_REQ);
                if (state_q == C_AL_REQ) begin
                    state_d = C_AL_WAIT;
                end else if (mem_to_cache_ready) begin
                    data_d[w_index]  = mem_to_cache_data;
                    tag_d[w_index]   = w_tag;
                    valid_d[w_index] = 1'b1;
                    dirty_d[w_index] = 1'b0;
                    // Back through COMPARE: guaranteed hit, which is where a
                    // pending write lands and cpu_ready is raised.
                    state_d          = C_COMPARE;
                end
            end

            default: state_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= C_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Request register and line payload carry no reset: they are only
    // meaningful behind the state machine and the valid bits.
    always_ff @(posedge clk) begin
        req_rw_q    <= req_rw_d;
        req_addr_q  <= req_addr_d;
        req_wdata_q <= req_wdata_d;
        tag_q       <= tag_d;
        data_q      <= data_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_cache_controller
// Purpose  : Self-checking bench for dm_cache_controller (LINES = 256) with a
//            behavioural RAM controller, a request log and a read scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_dm_cache_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_valid = 1'b0;
    logic        cpu_rw = 1'b0;
    logic [19:0] cpu_addr = 20'd0;
    logic [31:0] cpu_wdata = 32'd0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic [19:0] cache_to_mem_addr;
    logic [31:0] cache_to_mem_data;
    logic        cache_to_mem_rw;
    logic        cache_to_mem_valid;
    logic [31:0] mem_to_cache_data = 32'd0;
    logic        mem_to_cache_ready = 1'b0;

    always #5 clk = ~clk;

    dm_cache_controller #(.LINES(256)) dut (
        .clk                (clk),
        .rst                (rst),
        .cpu_valid          (cpu_valid),
        .cpu_rw             (cpu_rw),
        .cpu_addr           (cpu_addr),
        .cpu_wdata          (cpu_wdata),
        .cpu_rdata          (cpu_rdata),
        .cpu_ready          (cpu_ready),
        .cache_to_mem_addr  (cache_to_mem_addr),
        .cache_to_mem_data  (cache_to_mem_data),
        .cache_to_mem_rw    (cache_to_mem_rw),
        .cache_to_mem_valid (cache_to_mem_valid),
        .mem_to_cache_data  (mem_to_cache_data),
        .mem_to_cache_ready (mem_to_cache_ready)
    );

    typedef struct packed {
        logic        rw;
        logic [19:0] addr;
        logic [31:0] data;
    } txn_t;

    int          errors = 0;
    int          checks = 0;
    int          mem_lat = 1;
    logic [31:0] mem     [int];
    logic [31:0] ref_mem [int];
    txn_t        txn_log [$];
    logic [31:0] exp_q   [$];

    function automatic logic [31:0] init_val(input logic [19:0] a);
        return {a[11:0], a} ^ 32'h5A5A_1357;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [19:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return init_val(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [19:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return mem_rd(a);
    endfunction

    // Behavioural RAM controller: responds mem_lat cycles after a request.
    initial begin : g_mem_model
        logic busy;
        logic prev_v;
        int   cnt;
        txn_t cur;
        busy   = 1'b0;
        prev_v = 1'b0;
        cnt    = 0;
        cur    = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_to_cache_ready = 1'b0;
            mem_to_cache_data  = 32'd0;
            if (busy) begin
                cnt = cnt - 1;
                if (cnt <= 0) begin
                    busy = 1'b0;
                    mem_to_cache_ready = 1'b1;
                    if (cur.rw) mem[int'(cur.addr)] = cur.data;
                    else        mem_to_cache_data = mem_rd(cur.addr);
                end
            end
            if (cache_to_mem_valid) begin
                checks++;
                if (prev_v) begin
                    errors++;
                    $display("FAIL valid_pulse: valid high two cycles in a row (got 1 then 1, required 1 then 0)");
                end
                cur  = '{rw: cache_to_mem_rw, addr: cache_to_mem_addr, data: cache_to_mem_data};
                busy = 1'b1;
                cnt  = mem_lat;
                txn_log.push_back(cur);
            end
            prev_v = cache_to_mem_valid;
        end
    end

    // One CPU request; expected rdata goes into the scoreboard when driven
    // and is popped when cpu_ready appears. Called just after a clock edge.
    task automatic cpu_op(input logic rw, input logic [19:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd);
        logic [31:0] e;
        @(posedge clk);
        #1;
        if (rw) begin
            e = 32'd0;
            ref_mem[int'(a)] = wd;
        end else begin
            e = ref_rd(a);
        end
        exp_q.push_back(e);
        cpu_valid = 1'b1;
        cpu_rw    = rw;
        cpu_addr  = a;
        cpu_wdata = wd;
        @(posedge clk);
        #1;
        cpu_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 200 && !cpu_ready; i++) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = cpu_rdata;
        e  = exp_q.pop_front();
        checks++;
        if (!cpu_ready) begin
            errors++;
            $display("FAIL cpu_timeout addr=%05h: cpu_ready=0, required 1 within 200 cycles", a);
        end else if (cpu_rdata !== e) begin
            errors++;
            $display("FAIL rdata addr=%05h rw=%0b: got %08h, required %08h", a, rw, cpu_rdata, e);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (cpu_ready !== 1'b0 || cache_to_mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: ready=%b valid=%b, required 0 0", cpu_ready, cache_to_mem_valid);
        end
        checks++;
        if (cpu_rdata !== 32'd0 || cache_to_mem_addr !== 20'd0 || cache_to_mem_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_fields: rdata=%h addr=%h data=%h, required zeros",
                     cpu_rdata, cache_to_mem_addr, cache_to_mem_data);
        end
        rst = 1'b1;
    endtask

    task automatic test_clean_miss();
        int lat;
        logic [31:0] rd;
        mem_lat = 1;
        txn_log.delete();
        cpu_op(1'b0, 20'h00012, 32'd0, lat, rd);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL first_read_data: got %08h, required deadbeef", rd);
        end
        checks++;
        if (txn_log.size() != 1 || txn_log[0].rw !== 1'b0 || txn_log[0].addr !== 20'h00012) begin
            errors++;
            $display("FAIL first_read_txn: count=%0d, required one read of 00012", txn_log.size());
        end
        checks++;
        if (lat != mem_lat + 3) begin
            errors++;
            $display("FAIL clean_miss_latency: got %0d, required %0d", lat, mem_lat + 3);
        end
        txn_log.delete();
        cpu_op(1'b0, 20'h00012, 32'd0, lat, rd);
        checks++;
        if (lat != 1 || txn_log.size() != 0) begin
            errors++;
            $display("FAIL read_hit: latency=%0d txns=%0d, required 1 and 0", lat, txn_log.size());
        end
    endtask

    task automatic test_dirty_miss();
        int lat;
        logic [31:0] rd;
        txn_log.delete();
        cpu_op(1'b1, 20'h00012, 32'h11223344, lat, rd);
        checks++;
        if (lat != 1 || txn_log.size() != 0) begin
            errors++;
            $display("FAIL write_hit: latency=%0d txns=%0d, required 1 and 0", lat, txn_log.size());
        end
        txn_log.delete();
        cpu_op(1'b0, 20'h00112, 32'd0, lat, rd);
        checks++;
        if (txn_log.size() != 2) begin
            errors++;
            $display("FAIL dirty_miss_count: got %0d transactions, required 2", txn_log.size());
        end else begin
            checks++;
            if (txn_log[0] !== '{rw: 1'b1, addr: 20'h00012, data: 32'h11223344}) begin
                errors++;
                $display("FAIL writeback_txn: got rw=%b addr=%05h data=%08h, required 1 00012 11223344",
                         txn_log[0].rw, txn_log[0].addr, txn_log[0].data);
            end
            checks++;
            if (txn_log[1].rw !== 1'b0 || txn_log[1].addr !== 20'h00112) begin
                errors++;
                $display("FAIL refill_txn: got rw=%b addr=%05h, required 0 00112",
                         txn_log[1].rw, txn_log[1].addr);
            end
        end
        checks++;
        if (rd !== init_val(20'h00112)) begin
            errors++;
            $display("FAIL dirty_miss_data: got %08h, required %08h", rd, init_val(20'h00112));
        end
    endtask

    task automatic test_write_allocate();
        int lat;
        logic [31:0] rd;
        txn_log.delete();
        cpu_op(1'b1, 20'h00034, 32'hA5A5A5A5, lat, rd);
        checks++;
        if (txn_log.size() != 1 || txn_log[0].rw !== 1'b0 || txn_log[0].addr !== 20'h00034) begin
            errors++;
            $display("FAIL write_alloc_txn: count=%0d, required one read of 00034", txn_log.size());
        end
        txn_log.delete();
        cpu_op(1'b0, 20'h00034, 32'd0, lat, rd);
        checks++;
        if (rd !== 32'hA5A5A5A5 || lat != 1 || txn_log.size() != 0) begin
            errors++;
            $display("FAIL write_alloc_hit: data=%08h latency=%0d txns=%0d, required a5a5a5a5 1 0",
                     rd, lat, txn_log.size());
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        int seen;
        logic [31:0] rd;
        mem_lat = 4;
        @(posedge clk);
        #1;
        txn_log.delete();
        cpu_valid = 1'b1;
        cpu_rw    = 1'b0;
        cpu_addr  = 20'h00056;
        @(posedge clk);      // accepted -> COMPARE
        #1;
        cpu_valid = 1'b0;
        @(posedge clk);      // AL_REQ
        #1;
        @(posedge clk);      // AL_WAIT
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (cpu_ready) seen++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen != 0 || txn_log.size() != 1) begin
            errors++;
            $display("FAIL reset_abort: ready pulses=%0d txns=%0d, required 0 and 1", seen, txn_log.size());
        end
        mem_lat = 1;
        txn_log.delete();
        cpu_op(1'b0, 20'h00056, 32'd0, lat, rd);
        checks++;
        if (txn_log.size() != 1 || lat != 4) begin
            errors++;
            $display("FAIL reset_abort_remiss: txns=%0d latency=%0d, required 1 and 4", txn_log.size(), lat);
        end
        txn_log.delete();
        cpu_op(1'b0, 20'h00112, 32'd0, lat, rd);
        checks++;
        if (txn_log.size() != 1) begin
            errors++;
            $display("FAIL reset_invalidate: txns=%0d, required 1", txn_log.size());
        end
    endtask

    task automatic test_back_to_back();
        int          nready;
        logic [31:0] e;
        mem_lat = 1;
        e = ref_rd(20'h00078);
        @(posedge clk);
        #1;
        txn_log.delete();
        nready    = 0;
        cpu_valid = 1'b1;
        cpu_rw    = 1'b0;
        cpu_addr  = 20'h00078;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (cpu_ready) begin
                nready++;
                checks++;
                if (cpu_rdata !== e) begin
                    errors++;
                    $display("FAIL held_rdata: got %08h, required %08h", cpu_rdata, e);
                end
            end
        end
        cpu_valid = 1'b0;
        checks++;
        if (nready != 9 || txn_log.size() != 1) begin
            errors++;
            $display("FAIL held_valid: ready pulses=%0d txns=%0d, required 9 and 1", nready, txn_log.size());
        end
    endtask

    task automatic test_random();
        int          lat;
        logic [31:0] rd;
        logic        rw;
        logic [19:0] a;
        apply_reset();
        repeat (8) @(posedge clk);
        #1;
        ref_mem.delete();
        mem_lat = 2;
        for (int n = 0; n < 150; n++) begin
            rw = 1'($urandom_range(0, 1));
            a  = {10'd0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 7))};
            cpu_op(rw, a, $urandom, lat, rd);
        end
    endtask

    initial begin
        mem[32'h12] = 32'hDEADBEEF;
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_write_allocate();
        test_reset_abort();
        test_back_to_back();
        test_random();
        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
